alu_share_arbiter: RTL and testbench

- Shares one N-bit ALU (ADD/SUB/AND/OR, 4-bit ALU-control encoding) between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1).
- Each request port uses a valid/ready handshake. The arbiter grants fairly with a round-robin pointer.
- It computes the result and holds it in a one-entry response register until the consumer accepts it.
- It sits between the ALU control decoder and writeback.

---
 rtl/alu_share_arbiter_if.sv | 33 +++
 rtl/alu_share_arbiter.sv | 45 ++++
 tb/tb_alu_share_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle between two ALU requesters, the shared ALU and writeback
interface alu_share_arbiter_if #(parameter int N = 32);
    logic         req0_valid_i;
    logic         req0_ready_o;
    logic [3:0]   req0_op_i;
    logic [N-1:0] req0_a_i;
    logic [N-1:0] req0_b_i;
    logic         req1_valid_i;
    logic         req1_ready_o;
    logic [3:0]   req1_op_i;
    logic [N-1:0] req1_a_i;
    logic [N-1:0] req1_b_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         rsp_id_o;
    logic [N-1:0] rsp_result_o;
    logic         rsp_zero_o;
    logic         rsp_illegal_o;
    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        input  rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_illegal_o
    );
    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        output rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_illegal_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ADD/SUB/AND/OR ALU between two requesters,
// with a one-entry response register that may drain and reload in the same cycle.
module alu_share_arbiter #(parameter int N = 32) (
    input logic clk_i,
    input logic rst_i,
    alu_share_arbiter_if.slave bus
);
    logic         ptr, free, g0, g1, ill;
    logic [3:0]   op;
    logic [N-1:0] a, b, res;
    always_comb begin
        free = !bus.rsp_valid_o || bus.rsp_ready_i;
        g0   = !rst_i && free && bus.req0_valid_i && (!bus.req1_valid_i || !ptr);
        g1   = !rst_i && free && bus.req1_valid_i && (!bus.req0_valid_i || ptr);
        op   = g1 ? bus.req1_op_i : bus.req0_op_i;
        a    = g1 ? bus.req1_a_i : bus.req0_a_i;
        b    = g1 ? bus.req1_b_i : bus.req0_b_i;
        ill  = !(op inside {4'b0010, 4'b0110, 4'b0000, 4'b0001});
        res  = op == 4'b0010 ? a + b :
               op == 4'b0110 ? a - b :
               op == 4'b0000 ? a & b :
               op == 4'b0001 ? a | b : '0;
    end
    assign bus.req0_ready_o = g0;
    assign bus.req1_ready_o = g1;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr               <= 1'b0;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_id_o      <= 1'b0;
            bus.rsp_result_o  <= '0;
            bus.rsp_zero_o    <= 1'b0;
            bus.rsp_illegal_o <= 1'b0;
        end else if (g0 || g1) begin
            ptr               <= g0;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_id_o      <= g1;
            bus.rsp_result_o  <= res;
            bus.rsp_zero_o    <= res == '0;
            bus.rsp_illegal_o <= ill;
        end else if (bus.rsp_ready_i) begin
            bus.rsp_valid_o   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with hand-computed results; a grant model queues the
// expected responses and a monitor pops and compares each accepted response.
module tb_alu_share_arbiter;
    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } rsp_t;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000, OR = 4'b0001;
    logic clk, rst;
    int checks, errors;
    rsp_t q[$];
    logic glog[$];
    logic [31:0] e0, e1;
    logic i0, i1;
    logic mv, mptr, efree, eg0, eg1;
    logic hold;
    rsp_t prev;
    alu_share_arbiter_if #(.N(32)) bus();
    alu_share_arbiter #(.N(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction
    function automatic rsp_t mk(logic id, logic [31:0] res, logic ill);
        rsp_t r;
        r.id = id;
        r.res = res;
        r.zero = res == 32'd0;
        r.ill = ill;
        return r;
    endfunction
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic set0(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] ex, logic il);
        bus.req0_valid_i = 1'b1;
        bus.req0_op_i = op;
        bus.req0_a_i = a;
        bus.req0_b_i = b;
        e0 = ex;
        i0 = il;
    endtask
    task automatic set1(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] ex, logic il);
        bus.req1_valid_i = 1'b1;
        bus.req1_op_i = op;
        bus.req1_a_i = a;
        bus.req1_b_i = b;
        e1 = ex;
        i1 = il;
    endtask
    // grant model: expected readys each cycle, expected response queued on each grant
    always @(negedge clk) begin
        if (rst) begin
            chk("ready0_in_reset", {63'd0, bus.req0_ready_o}, 64'd0);
            chk("ready1_in_reset", {63'd0, bus.req1_ready_o}, 64'd0);
            mv = 1'b0;
            mptr = 1'b0;
            q.delete();
        end else begin
            efree = !mv || bus.rsp_ready_i;
            eg0 = efree && bus.req0_valid_i && (!bus.req1_valid_i || !mptr);
            eg1 = efree && bus.req1_valid_i && (!bus.req0_valid_i || mptr);
            chk("ready0", {63'd0, bus.req0_ready_o}, {63'd0, eg0});
            chk("ready1", {63'd0, bus.req1_ready_o}, {63'd0, eg1});
            if (eg0) begin
                q.push_back(mk(1'b0, e0, i0));
                glog.push_back(1'b0);
                mv = 1'b1;
                mptr = 1'b1;
            end else if (eg1) begin
                q.push_back(mk(1'b1, e1, i1));
                glog.push_back(1'b1);
                mv = 1'b1;
                mptr = 1'b0;
            end else if (bus.rsp_ready_i) begin
                mv = 1'b0;
            end
        end
    end
    // response monitor: compare on every accepted response and check stability under backpressure
    always @(negedge clk) begin
        rsp_t cur, ex;
        cur = {bus.rsp_id_o, bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_illegal_o};
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("rsp_stable", {29'd0, cur}, {29'd0, prev});
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", {29'd0, cur}, 64'd0);
                end else begin
                    ex = q.pop_front();
                    chk("rsp", {29'd0, cur}, {29'd0, ex});
                end
            end
            hold = bus.rsp_valid_o && !bus.rsp_ready_i;
            prev = cur;
        end
    end
    initial begin
        checks = 0;
        errors = 0;
        hold = 1'b0;
        rst = 1'b1;
        {bus.req0_valid_i, bus.req0_op_i, bus.req0_a_i, bus.req0_b_i} = '0;
        {bus.req1_valid_i, bus.req1_op_i, bus.req1_a_i, bus.req1_b_i} = '0;
        bus.rsp_ready_i = 1'b0;
        {e0, e1, i0, i1} = '0;
        cycle();
        set0(ADD, 32'd1, 32'd1, 32'd2, 1'b0);
        set1(ADD, 32'd1, 32'd1, 32'd2, 1'b0);
        cycle();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        rst = 1'b0;
        chk("reset_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
        chk("reset_id", {63'd0, bus.rsp_id_o}, 64'd0);
        chk("reset_result", {32'd0, bus.rsp_result_o}, 64'd0);
        chk("reset_zero", {63'd0, bus.rsp_zero_o}, 64'd0);
        chk("reset_illegal", {63'd0, bus.rsp_illegal_o}, 64'd0);
        // single request
        bus.rsp_ready_i = 1'b1;
        set0(ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        cycle();
        bus.req0_valid_i = 1'b0;
        chk("single_result", {32'd0, bus.rsp_result_o}, 64'd12);
        cycle();
        // lone port-1 request leaves the pointer on port 0
        set1(AND, 32'hFF, 32'h0F, 32'h0F, 1'b0);
        cycle();
        bus.req1_valid_i = 1'b0;
        // contention
        glog.delete();
        set0(ADD, 32'd1, 32'd1, 32'd2, 1'b0);
        set1(SUB, 32'd9, 32'd4, 32'd5, 1'b0);
        repeat (4) cycle();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        chk("grant_count", glog.size(), 64'd4);
        if (glog.size() == 4) begin
            chk("grant0", {63'd0, glog[0]}, 64'd0);
            chk("grant1", {63'd0, glog[1]}, 64'd1);
            chk("grant2", {63'd0, glog[2]}, 64'd0);
            chk("grant3", {63'd0, glog[3]}, 64'd1);
        end
        // backpressure
        set1(OR, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        cycle();
        bus.req1_valid_i = 1'b0;
        set0(ADD, 32'd2, 32'd3, 32'd5, 1'b0);
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_result", {32'd0, bus.rsp_result_o}, 64'hFF);
            chk("bp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        end
        bus.rsp_ready_i = 1'b1;
        cycle();
        bus.req0_valid_i = 1'b0;
        chk("bp_next_result", {32'd0, bus.rsp_result_o}, 64'd5);
        cycle();
        // arithmetic edges
        set0(ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        cycle();
        chk("add_wrap_zero", {63'd0, bus.rsp_zero_o}, 64'd1);
        set0(SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
        cycle();
        set0(AND, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd0, 1'b0);
        cycle();
        // illegal opcode then a legal one
        set0(4'b0111, 32'd3, 32'd3, 32'd0, 1'b1);
        cycle();
        chk("illegal_flag", {63'd0, bus.rsp_illegal_o}, 64'd1);
        set0(OR, 32'd1, 32'd2, 32'd3, 1'b0);
        cycle();
        bus.req0_valid_i = 1'b0;
        chk("illegal_cleared", {63'd0, bus.rsp_illegal_o}, 64'd0);
        cycle();
        // reset with a response pending and the pointer on port 1
        bus.rsp_ready_i = 1'b0;
        set0(ADD, 32'd4, 32'd4, 32'd8, 1'b0);
        cycle();
        bus.req0_valid_i = 1'b0;
        cycle();
        chk("pending_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midreset_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
        glog.delete();
        bus.rsp_ready_i = 1'b1;
        set0(ADD, 32'd1, 32'd2, 32'd3, 1'b0);
        set1(SUB, 32'd5, 32'd5, 32'd0, 1'b0);
        cycle();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        chk("post_reset_grants", glog.size(), 64'd1);
        if (glog.size() != 0) chk("post_reset_first", {63'd0, glog[0]}, 64'd0);
        repeat (2) cycle();
        chk("queue_drained", q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
